mem_sync: RTL and testbench

- Clocked, parametrised successor to the combinational scratch memory.
- Holds MEM_SIZE bytes organised as lines of N_WORDS_PER_ADDR words of BITSIZE bits.
- Serves one request at a time through a valid/ready request channel and a valid/ready response channel, with programmable access latency, per-word write strobes and out-of-range error reporting.
- Sits behind the instruction/data memory controller as the backing store for simulation and FPGA builds.

---
 rtl/mem_sync.sv | 177 +++++++++++++++++
 tb/tb_mem_sync.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync.sv
// ============================================================================
// Module   : mem_sync
// Brief    : Clocked line-organised scratch memory with valid/ready request and
//            response channels, programmable latency, per-word write strobes and
//            out-of-range error responses. The array starts at 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_sync #(
    parameter int BITSIZE          = 32,
    parameter int N_WORDS_PER_ADDR = 4,
    parameter int MEM_SIZE         = 1024,
    parameter int LATENCY          = 2,
    parameter     INIT_FILE        = "mem_init.hex"
) (
    input  logic                                  clk,
    input  logic                                  reset_i,
    input  logic [31:0]                           mem_addr_i,
    input  logic [N_WORDS_PER_ADDR*BITSIZE-1:0]   mem_data_i,
    input  logic [N_WORDS_PER_ADDR-1:0]           mem_wstrb_i,
    input  logic                                  mem_store_i,
    input  logic                                  mem_valid_i,
    output logic                                  mem_ready_o,
    output logic [N_WORDS_PER_ADDR*BITSIZE-1:0]   mem_data_o,
    output logic                                  mem_err_o,
    output logic                                  mem_valid_o,
    input  logic                                  mem_ready_i
);

    localparam int LINE_W     = N_WORDS_PER_ADDR * BITSIZE;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int ADDR_W     = $clog2(MEM_SIZE);
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int N_LINES    = MEM_SIZE / LINE_BYTES;
    localparam int IDX_W      = (N_LINES > 1) ? $clog2(N_LINES) : 1;
    localparam int CNT_W      = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]                  r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [31:0]                 r_addr;
    logic [LINE_W-1:0]           r_wdata;
    logic [N_WORDS_PER_ADDR-1:0] r_wstrb;
    logic                        r_store;
    logic [LINE_W-1:0]           r_data_o;
    logic                        r_err;

    logic                        w_accept;
    logic                        w_do_access;
    logic [31:0]                 w_acc_addr;
    logic [LINE_W-1:0]           w_acc_wdata;
    logic [N_WORDS_PER_ADDR-1:0] w_acc_wstrb;
    logic                        w_acc_store;
    logic [IDX_W-1:0]            w_idx;
    logic                        w_oor;
    logic [LINE_W-1:0]           w_cur_line;
    logic [LINE_W-1:0]           w_new_line;
    logic                        w_unused_offset;

    logic [LINE_W-1:0] r_mem [N_LINES] = '{default: '0};

    // Reset gates ready so a request presented alongside reset is never accepted.
    assign mem_ready_o = (r_state == S_IDLE) && !reset_i;
    assign mem_valid_o = (r_state == S_RESP);
    assign mem_data_o  = r_data_o;
    assign mem_err_o   = r_err;
    assign w_accept    = mem_valid_i && mem_ready_o;

    // With single-cycle latency the access uses the request as presented;
    // otherwise it uses the copy captured at acceptance.
    generate
        if (LATENCY == 1) begin : g_lat_one
            assign w_acc_addr  = mem_addr_i;
            assign w_acc_wdata = mem_data_i;
            assign w_acc_wstrb = mem_wstrb_i;
            assign w_acc_store = mem_store_i;
            assign w_do_access = w_accept;
        end else begin : g_lat_multi
            assign w_acc_addr  = r_addr;
            assign w_acc_wdata = r_wdata;
            assign w_acc_wstrb = r_wstrb;
            assign w_acc_store = r_store;
            assign w_do_access = (r_state == S_WAIT) && (r_cnt == '0) && !reset_i;
        end
    endgenerate

    generate
        if (N_LINES > 1) begin : g_idx_multi
            assign w_idx = w_acc_addr[ADDR_W-1:OFF_W];
        end else begin : g_idx_single
            assign w_idx = '0;
        end
    endgenerate

    assign w_oor           = |w_acc_addr[31:ADDR_W];
    assign w_cur_line      = r_mem[w_idx];
    assign w_unused_offset = ^w_acc_addr[OFF_W-1:0];

    always_comb begin
        w_new_line = w_cur_line;
        for (int k = 0; k < N_WORDS_PER_ADDR; k++) begin
            if (w_acc_wstrb[k]) begin
                w_new_line[k*BITSIZE +: BITSIZE] = w_acc_wdata[k*BITSIZE +: BITSIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_store  <= 1'b0;
            r_data_o <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= mem_addr_i;
                        r_wdata <= mem_data_i;
                        r_wstrb <= mem_wstrb_i;
                        r_store <= mem_store_i;
                        if (LATENCY == 1) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= C_CNT_INIT;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (mem_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Response registers only change on an access, so they hold after valid drops.
            if (w_do_access) begin
                r_err <= w_oor;
                if (w_oor) begin
                    r_data_o <= '0;
                end else if (w_acc_store) begin
                    r_data_o <= w_new_line;
                end else begin
                    r_data_o <= w_cur_line;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_access && w_acc_store && !w_oor) begin
            r_mem[w_idx] <= w_new_line;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_sync.sv
// ============================================================================
// Module   : tb_mem_sync
// Brief    : Directed self-checking bench for mem_sync (LATENCY=2 and LATENCY=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_sync;

    logic         clk = 1'b0;
    int           n_checks = 0;
    int           n_fail   = 0;

    // LATENCY = 2 instance
    logic         reset_i = 1'b1;
    logic [31:0]  mem_addr_i = '0;
    logic [127:0] mem_data_i = '0;
    logic [3:0]   mem_wstrb_i = '0;
    logic         mem_store_i = 1'b0;
    logic         mem_valid_i = 1'b0;
    logic         mem_ready_o;
    logic [127:0] mem_data_o;
    logic         mem_err_o;
    logic         mem_valid_o;
    logic         mem_ready_i = 1'b1;

    // LATENCY = 3 instance
    logic         reset3 = 1'b1;
    logic [31:0]  addr3 = '0;
    logic [127:0] wdata3 = '0;
    logic [3:0]   wstrb3 = '0;
    logic         store3 = 1'b0;
    logic         valid_in3 = 1'b0;
    logic         ready_out3;
    logic [127:0] rdata3;
    logic         err3;
    logic         valid_out3;
    logic         ready_in3 = 1'b1;

    always #5 clk = ~clk;

    mem_sync #(.LATENCY(2)) u_dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_store_i (mem_store_i),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_data_o  (mem_data_o),
        .mem_err_o   (mem_err_o),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i)
    );

    mem_sync #(.LATENCY(3)) u_dut3 (
        .clk         (clk),
        .reset_i     (reset3),
        .mem_addr_i  (addr3),
        .mem_data_i  (wdata3),
        .mem_wstrb_i (wstrb3),
        .mem_store_i (store3),
        .mem_valid_i (valid_in3),
        .mem_ready_o (ready_out3),
        .mem_data_o  (rdata3),
        .mem_err_o   (err3),
        .mem_valid_o (valid_out3),
        .mem_ready_i (ready_in3)
    );

    localparam logic [127:0] LINE_A  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] ALL_A   = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
    localparam logic [127:0] PART_A  = 128'h00000000_AAAAAAAA_00000000_AAAAAAAA;
    localparam logic [127:0] ALL_F   = {128{1'b1}};
    localparam logic [127:0] OLD_30  = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    localparam logic [127:0] NEW_30  = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;

    // Issue one request on the LATENCY=2 instance; lat counts edges from acceptance to valid.
    task automatic do_req(input logic [31:0] addr, input logic [127:0] wdata,
                          input logic [3:0] wstrb, input logic store,
                          output logic [127:0] rdata, output logic rerr, output int lat);
        int waited;
        @(negedge clk);
        mem_addr_i  = addr;
        mem_data_i  = wdata;
        mem_wstrb_i = wstrb;
        mem_store_i = store;
        mem_valid_i = 1'b1;
        mem_ready_i = 1'b1;
        waited = 0;
        while (!mem_ready_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        lat = 0;
        @(negedge clk);
        mem_valid_i = 1'b0;
        lat = 1;
        while (!mem_valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!mem_valid_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout addr=%h: no response within bound", addr);
        end
        rdata = mem_data_o;
        rerr  = mem_err_o;
    endtask

    task automatic do_req3(input logic [31:0] addr, input logic [127:0] wdata,
                           input logic [3:0] wstrb, input logic store,
                           output logic [127:0] rdata, output logic rerr, output int lat);
        int waited;
        @(negedge clk);
        addr3     = addr;
        wdata3    = wdata;
        wstrb3    = wstrb;
        store3    = store;
        valid_in3 = 1'b1;
        ready_in3 = 1'b1;
        waited = 0;
        while (!ready_out3 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        valid_in3 = 1'b0;
        lat = 1;
        while (!valid_out3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!valid_out3) begin
            n_checks++;
            n_fail++;
            $display("FAIL req3_timeout addr=%h: no response within bound", addr);
        end
        rdata = rdata3;
        rerr  = err3;
    endtask

    task automatic test_reset();
        logic [127:0] d;
        logic         e;
        int           lat;
        reset_i = 1'b1;
        reset3  = 1'b1;
        mem_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", mem_ready_o); end
        n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", mem_valid_o); end
        n_checks++; if (mem_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", mem_err_o); end
        n_checks++; if (mem_data_o !== 128'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", mem_data_o); end
        mem_valid_i = 1'b0;
        reset_i = 1'b0;
        reset3  = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", mem_ready_o); end
        n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: got %b want 0", mem_valid_o); end
        do_req(32'h0, '0, 4'h0, 1'b0, d, e, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL load0_latency: got %0d want 2", lat); end
        n_checks++; if (d !== 128'h0) begin n_fail++; $display("FAIL load0_data: got %h want 0", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL load0_err: got %b want 0", e); end
    endtask

    task automatic test_store_load();
        logic [127:0] d;
        logic         e;
        int           lat;
        do_req(32'h10, LINE_A, 4'b1111, 1'b1, d, e, lat);
        n_checks++; if (d !== LINE_A) begin n_fail++; $display("FAIL store10_resp: got %h want %h", d, LINE_A); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL store10_err: got %b want 0", e); end
        do_req(32'h1C, '0, 4'h0, 1'b0, d, e, lat);
        n_checks++; if (d !== LINE_A) begin n_fail++; $display("FAIL load1c_data: got %h want %h", d, LINE_A); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL load1c_latency: got %0d want 2", lat); end
    endtask

    task automatic test_partial_strobe();
        logic [127:0] d;
        logic         e;
        int           lat;
        do_req(32'h20, ALL_A, 4'b0101, 1'b1, d, e, lat);
        n_checks++; if (d !== PART_A) begin n_fail++; $display("FAIL strb_resp: got %h want %h", d, PART_A); end
        do_req(32'h20, '0, 4'h0, 1'b0, d, e, lat);
        n_checks++; if (d !== PART_A) begin n_fail++; $display("FAIL strb_load: got %h want %h", d, PART_A); end
        // Zero strobe: full response, line untouched.
        do_req(32'h24, ALL_F, 4'b0000, 1'b1, d, e, lat);
        n_checks++; if (d !== PART_A) begin n_fail++; $display("FAIL zero_strb_resp: got %h want %h", d, PART_A); end
        do_req(32'h20, '0, 4'h0, 1'b0, d, e, lat);
        n_checks++; if (d !== PART_A) begin n_fail++; $display("FAIL zero_strb_load: got %h want %h", d, PART_A); end
    endtask

    task automatic test_out_of_range();
        logic [127:0] d;
        logic         e;
        int           lat;
        do_req(32'h400, '0, 4'h0, 1'b0, d, e, lat);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_load_err: got %b want 1", e); end
        n_checks++; if (d !== 128'h0) begin n_fail++; $display("FAIL oor_load_data: got %h want 0", d); end
        do_req(32'h400, ALL_F, 4'b1111, 1'b1, d, e, lat);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_store_err: got %b want 1", e); end
        n_checks++; if (d !== 128'h0) begin n_fail++; $display("FAIL oor_store_data: got %h want 0", d); end
        do_req(32'h0, '0, 4'h0, 1'b0, d, e, lat);
        n_checks++; if (d !== 128'h0) begin n_fail++; $display("FAIL oor_alias0: got %h want 0", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear: got %b want 0", e); end
        do_req(32'h10, '0, 4'h0, 1'b0, d, e, lat);
        n_checks++; if (d !== LINE_A) begin n_fail++; $display("FAIL oor_line10: got %h want %h", d, LINE_A); end
        do_req(32'h3F0, '0, 4'h0, 1'b0, d, e, lat);
        n_checks++; if (d !== 128'h0 || e !== 1'b0) begin n_fail++; $display("FAIL last_line: got %h/%b want 0/0", d, e); end
        do_req(32'h8000_0000, '0, 4'h0, 1'b0, d, e, lat);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_msb_err: got %b want 1", e); end
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        logic         e;
        int           waited;
        @(negedge clk);
        mem_addr_i  = 32'h10;
        mem_store_i = 1'b0;
        mem_wstrb_i = 4'h0;
        mem_valid_i = 1'b1;
        mem_ready_i = 1'b0;
        @(negedge clk);
        // Present a competing store while the response is stalled; it must be ignored.
        mem_addr_i  = 32'h10;
        mem_data_i  = ALL_F;
        mem_wstrb_i = 4'b1111;
        mem_store_i = 1'b1;
        waited = 0;
        while (!mem_valid_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++; if (mem_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_rise: got %b want 1", mem_valid_o); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (mem_valid_o !== 1'b1 || mem_data_o !== LINE_A || mem_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b data=%h want 1/0/%h", i, mem_valid_o, mem_ready_o, mem_data_o, LINE_A);
            end
            @(negedge clk);
        end
        mem_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_valid_o !== 1'b0 || mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", mem_valid_o, mem_ready_o); end
        n_checks++; if (mem_data_o !== LINE_A) begin n_fail++; $display("FAIL bp_data_hold: got %h want %h", mem_data_o, LINE_A); end
        do_req(32'h10, '0, 4'h0, 1'b0, d, e, waited);
        n_checks++; if (d !== LINE_A) begin n_fail++; $display("FAIL bp_ignored_store: got %h want %h", d, LINE_A); end
    endtask

    task automatic test_reset_in_wait();
        logic [127:0] d;
        logic         e;
        int           lat;
        bit           seen;
        do_req3(32'h30, OLD_30, 4'b1111, 1'b1, d, e, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL l3_latency: got %0d want 3", lat); end
        n_checks++; if (d !== OLD_30) begin n_fail++; $display("FAIL l3_store_resp: got %h want %h", d, OLD_30); end
        @(negedge clk);
        addr3     = 32'h30;
        wdata3    = NEW_30;
        wstrb3    = 4'b1111;
        store3    = 1'b1;
        valid_in3 = 1'b1;
        @(negedge clk);
        valid_in3 = 1'b0;
        reset3    = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) reset3 = 1'b0;
            if (valid_out3) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rw_valid_seen: got %b want 0", seen); end
        do_req3(32'h30, '0, 4'h0, 1'b0, d, e, lat);
        n_checks++; if (d !== OLD_30) begin n_fail++; $display("FAIL rw_old_contents: got %h want %h", d, OLD_30); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_partial_strobe();
        test_out_of_range();
        test_backpressure();
        test_reset_in_wait();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
